// File: rtl/gpi_irq.sv
// gpi_irq: general-purpose input core for one slot of the SoC slot bus.
//
// Samples W asynchronous inputs through a SYNC_STAGES-deep synchroniser.
// Optionally debounces each bit; this feature is compiled in only when the
// macro DEBOUNCE_EN is defined. Detects rising and falling edges, latches
// enabled edges into a write-1-to-clear status register, and raises a level
// interrupt while any status bit is pending and the interrupt is enabled.
//
// Register map (addr, access, content); unused upper bits read 0:
//   0  RO    filtered input value
//   1  RW    rise_en[W-1:0]
//   2  RW    fall_en[W-1:0]
//   3  W1C   status[W-1:0]
//   4  RW    irq_en (bit 0)
//   5..31    read 0, writes ignored
//
// Ports:
//   clk      system clock
//   reset    asynchronous active-low reset
//   cs       slot chip select
//   read     read strobe (reads have no side effects, so it is unused)
//   write    write strobe, qualified by cs
//   addr     register index
//   wr_data  write data
//   rd_data  read data, combinational mux of registered state
//   data_in  external inputs, asynchronous to clk
//   irq      level interrupt
module gpi_irq #(
  parameter int unsigned W           = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_LIMIT    = 1000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cs,
  input  logic          read,
  input  logic          write,
  input  logic [4:0]    addr,
  input  logic [31:0]   wr_data,
  output logic [31:0]   rd_data,
  input  logic [W-1:0]  data_in,
  output logic          irq
);

  logic [W-1:0] sync_q [SYNC_STAGES];
  logic [W-1:0] sync;
  logic [W-1:0] filt;
  logic [W-1:0] filt_d_q;
  logic [W-1:0] rise_en_q;
  logic [W-1:0] fall_en_q;
  logic [W-1:0] status_q;
  logic [W-1:0] status_d;
  logic         irq_en_q;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic [W-1:0] set;
  logic [W-1:0] clr;
  logic         we;

  // Only the whole bus is observed for read strobe and upper write bits.
  logic unused_inputs;
  assign unused_inputs = ^{read, wr_data};

  // Synchroniser chain; the last stage is the first value safe to use.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= data_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

`ifdef DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DB_LIMIT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DB_LIMIT - 1);

  logic [CntW-1:0] cnt_q [W];
  logic [W-1:0]    filt_q;

  // A bit's new level is accepted only after DB_LIMIT consecutive cycles of
  // disagreement; any agreement in between restarts the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_q <= '0;
      for (int i = 0; i < W; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < W; i++) begin
        if (sync[i] == filt_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CntMax) begin
          filt_q[i] <= sync[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  assign filt = filt_q;
`else
  assign filt = sync;

  // Debounce length has no meaning without the filter.
  logic [31:0] unused_db_limit;
  assign unused_db_limit = DB_LIMIT;
`endif

  assign we   = cs & write;
  assign rise = filt & ~filt_d_q;
  assign fall = ~filt & filt_d_q;

  // A newly detected enabled edge wins over a simultaneous W1C.
  always_comb begin
    set      = (rise & rise_en_q) | (fall & fall_en_q);
    clr      = (we && (addr == 5'd3)) ? wr_data[W-1:0] : '0;
    status_d = set | (status_q & ~clr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_d_q  <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      irq_en_q  <= 1'b0;
    end else begin
      filt_d_q <= filt;
      status_q <= status_d;
      if (we) begin
        case (addr)
          5'd1:    rise_en_q <= wr_data[W-1:0];
          5'd2:    fall_en_q <= wr_data[W-1:0];
          5'd4:    irq_en_q  <= wr_data[0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      5'd0:    rd_data = 32'(filt);
      5'd1:    rd_data = 32'(rise_en_q);
      5'd2:    rd_data = 32'(fall_en_q);
      5'd3:    rd_data = 32'(status_q);
      5'd4:    rd_data = {31'b0, irq_en_q};
      default: rd_data = '0;
    endcase
  end

  assign irq = irq_en_q & (|status_q);

endmodule

// File: tb/tb_gpi_irq.sv
module tb_gpi_irq;

  localparam int unsigned W          = 8;
  localparam int unsigned SyncStages = 2;
`ifdef DEBOUNCE_EN
  localparam int unsigned DbLimit = 4;
  localparam int unsigned Lat     = SyncStages + DbLimit;
`else
  localparam int unsigned DbLimit = 1000;
  localparam int unsigned Lat     = SyncStages;
`endif

  logic          clk;
  logic          reset;
  logic          cs;
  logic          read;
  logic          write;
  logic [4:0]    addr;
  logic [31:0]   wr_data;
  logic [31:0]   rd_data;
  logic [W-1:0]  data_in;
  logic          irq;

  gpi_irq #(
    .W          (W),
    .SYNC_STAGES(SyncStages),
    .DB_LIMIT   (DbLimit)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .cs     (cs),
    .read   (read),
    .write  (write),
    .addr   (addr),
    .wr_data(wr_data),
    .rd_data(rd_data),
    .data_in(data_in),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic push_exp(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL sb_empty: observed %h, nothing expected", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s: observed %h required %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    addr = a;
    read = 1'b1;
    #1;
    d    = rd_data;
    read = 1'b0;
  endtask

  task automatic exp_rd(input string tag, input logic [4:0] a, input logic [31:0] v);
    logic [31:0] d;
    push_exp(tag, v);
    rd(a, d);
    check(d);
  endtask

  task automatic exp_irq(input string tag, input logic v);
    push_exp(tag, {31'b0, v});
    #1;
    check({31'b0, irq});
  endtask

  // One bus write; consumes exactly one rising edge and returns at a falling edge.
  task automatic wr(input logic c, input logic [4:0] a, input logic [31:0] d);
    cs      = c;
    write   = 1'b1;
    addr    = a;
    wr_data = d;
    @(posedge clk);
    #1;
    cs      = 1'b0;
    write   = 1'b0;
    wr_data = '0;
    @(negedge clk);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset   = 1'b1;
    cs      = 1'b0;
    read    = 1'b0;
    write   = 1'b0;
    addr    = '0;
    wr_data = '0;
    data_in = 8'hFF;
    #2 reset = 1'b0;
    tick(2);

    // Reset state with inputs already high.
    for (int a = 0; a < 5; a++) begin
      exp_rd($sformatf("rst_addr%0d", a), 5'(a), 32'h0);
    end
    exp_irq("rst_irq", 1'b0);

    // Release: filtered value appears exactly Lat edges later, no event.
    @(negedge clk);
    reset = 1'b1;
    tick(Lat - 1);
    exp_rd("filt_early", 5'd0, 32'h0);
    tick(1);
    exp_rd("filt_lat", 5'd0, 32'hFF);
    exp_rd("rel_status", 5'd3, 32'h0);
    exp_irq("rel_irq", 1'b0);

    // Enabled rise on bit0 sets status and irq one edge after filt.
    wr(1'b1, 5'd1, 32'h01);
    wr(1'b1, 5'd4, 32'h1);
    data_in = 8'hFE;
    tick(Lat + 2);
    exp_rd("fall_unmasked_off", 5'd3, 32'h0);
    data_in = 8'hFF;
    tick(Lat);
    exp_rd("rise_early", 5'd3, 32'h0);
    exp_irq("irq_early", 1'b0);
    tick(1);
    exp_rd("rise_set", 5'd3, 32'h01);
    exp_irq("irq_set", 1'b1);
    wr(1'b1, 5'd3, 32'h01);
    exp_rd("w1c_clear", 5'd3, 32'h0);
    exp_irq("irq_clear", 1'b0);

    // Fall on bit7 latched; masked rise on bit6 discarded.
    wr(1'b1, 5'd2, 32'h80);
    data_in = 8'h7F;
    tick(Lat + 1);
    exp_rd("fall_set", 5'd3, 32'h80);
    exp_irq("fall_irq", 1'b1);
    data_in = 8'h3F;
    tick(Lat + 2);
    data_in = 8'h7F;
    tick(Lat + 2);
    exp_rd("rise_masked", 5'd3, 32'h80);
    wr(1'b1, 5'd3, 32'h80);
    exp_rd("w1c_bit7", 5'd3, 32'h0);

    // W1C on the very edge a new enabled rise is latched: set wins.
    data_in = 8'h7E;
    tick(Lat + 2);
    exp_rd("pre_race", 5'd3, 32'h0);
    data_in = 8'h7F;
    tick(Lat);
    wr(1'b1, 5'd3, 32'h01);
    exp_rd("set_wins", 5'd3, 32'h01);
    wr(1'b1, 5'd3, 32'h01);
    exp_rd("post_race_clr", 5'd3, 32'h0);

    // Unmapped address and deselected writes are ignored.
    wr(1'b1, 5'd1, 32'h0);
    wr(1'b1, 5'd7, 32'hFFFF_FFFF);
    wr(1'b0, 5'd1, 32'hFFFF_FFFF);
    exp_rd("cs_low_ignored", 5'd1, 32'h0);
    exp_rd("addr7_zero", 5'd7, 32'h0);
    wr(1'b1, 5'd1, 32'hFFFF_FFFF);
    exp_rd("rise_en_width", 5'd1, 32'hFF);
    exp_rd("fall_en_kept", 5'd2, 32'h80);
    wr(1'b1, 5'd4, 32'hFFFF_FFFF);
    exp_rd("irq_en_bit0", 5'd4, 32'h1);
    exp_rd("addr31_zero", 5'd31, 32'h0);

    // Mid-operation reset clears pending status immediately.
    data_in = 8'hFF;
    tick(Lat + 1);
    exp_rd("pre_reset_status", 5'd3, 32'h80);
    reset = 1'b0;
    #1;
    exp_rd("mid_rst_status", 5'd3, 32'h0);
    exp_irq("mid_rst_irq", 1'b0);
    exp_rd("mid_rst_rise_en", 5'd1, 32'h0);
    exp_rd("mid_rst_filt", 5'd0, 32'h0);
    tick(1);
    reset = 1'b1;
    tick(Lat + 3);
    exp_rd("rerel_filt", 5'd0, 32'hFF);
    exp_rd("rerel_status", 5'd3, 32'h0);
    exp_irq("rerel_irq", 1'b0);

`ifdef DEBOUNCE_EN
    begin
      logic [31:0] d;
      logic        seen;
      wr(1'b1, 5'd1, 32'h04);
      data_in = 8'h00;
      tick(Lat + 2);
      exp_rd("db_base", 5'd0, 32'h0);
      // Glitch one cycle shorter than the debounce window.
      seen    = 1'b0;
      data_in = 8'h04;
      for (int c = 0; c < 3; c++) begin
        tick(1);
        rd(5'd0, d);
        if (d[2]) seen = 1'b1;
      end
      data_in = 8'h00;
      for (int c = 0; c < int'(Lat) + 4; c++) begin
        tick(1);
        rd(5'd0, d);
        if (d[2]) seen = 1'b1;
      end
      push_exp("db_glitch_filt", 32'h0);
      check({31'b0, seen});
      exp_rd("db_glitch_status", 5'd3, 32'h0);
      // Held exactly long enough.
      data_in = 8'h04;
      tick(Lat - 1);
      exp_rd("db_early", 5'd0, 32'h0);
      tick(1);
      exp_rd("db_accept", 5'd0, 32'h04);
      tick(1);
      exp_rd("db_status", 5'd3, 32'h04);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
